// File: rtl/pupil_pkg.sv
// Shared types, widths, default marker centre and the coordinate clamp helper
// for the pupil marker controller.
package pupil_pkg;

  localparam int COORD_W = 13;
  localparam int PIX_W   = 10;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [PIX_W-1:0]   pix_t;

  localparam coord_t DEF_CENTRE_X = 13'd520;
  localparam coord_t DEF_CENTRE_Y = 13'd420;
  localparam pix_t   PIX_MAX      = '1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_SCAN     = 2'd2
  } state_e;

  function automatic coord_t clamp_coord(input coord_t v, input coord_t lo, input coord_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/pupil_marker_ctrl_if.sv
// Pixel stream, enable switch and committed marker box of the pupil marker
// controller; master drives the stream, slave is the controller.
interface pupil_marker_ctrl_if;
  import pupil_pkg::*;

  logic   iEN;
  logic   iDVAL;
  coord_t iH_Cont;
  coord_t iV_Cont;
  pix_t   iGRAY;

  coord_t oBOX_X0;
  coord_t oBOX_X1;
  coord_t oBOX_Y0;
  coord_t oBOX_Y1;
  logic   oBOX_VALID;
  pix_t   oMIN_VAL;
  logic   oBUSY;

  modport master (
    output iEN, iDVAL, iH_Cont, iV_Cont, iGRAY,
    input  oBOX_X0, oBOX_X1, oBOX_Y0, oBOX_Y1, oBOX_VALID, oMIN_VAL, oBUSY
  );

  modport slave (
    input  iEN, iDVAL, iH_Cont, iV_Cont, iGRAY,
    output oBOX_X0, oBOX_X1, oBOX_Y0, oBOX_Y1, oBOX_VALID, oMIN_VAL, oBUSY
  );

endinterface

// File: rtl/pupil_min_tracker.sv
// Darkest-pixel accumulator over the region of interest: strict-less compare,
// so the first pixel in raster order wins a tie.
module pupil_min_tracker
  import pupil_pkg::*;
#(
  parameter coord_t ROI_X0 = 13'd256,
  parameter coord_t ROI_X1 = 13'd640,
  parameter coord_t ROI_Y0 = 13'd8,
  parameter coord_t ROI_Y1 = 13'd472
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   init_i,
  input  logic   en_i,
  input  logic   dval_i,
  input  coord_t h_i,
  input  coord_t v_i,
  input  pix_t   gray_i,
  output pix_t   min_o,
  output coord_t cand_x_o,
  output coord_t cand_y_o
);

  pix_t   min_q, min_d;
  coord_t cand_x_q, cand_x_d;
  coord_t cand_y_q, cand_y_d;
  logic   in_roi;
  logic   take;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    min_d    = min_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    in_roi   = (h_i >= ROI_X0) && (h_i < ROI_X1) && (v_i >= ROI_Y0) && (v_i < ROI_Y1);
    take     = en_i && dval_i && in_roi && (gray_i < min_q);
    if (init_i) begin
      min_d    = PIX_MAX;
      cand_x_d = '0;
      cand_y_d = '0;
    end else if (take) begin
      min_d    = gray_i;
      cand_x_d = h_i;
      cand_y_d = v_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      min_q    <= PIX_MAX;
      cand_x_q <= '0;
      cand_y_q <= '0;
    end else begin
      min_q    <= min_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
    end
  end

  assign min_o    = min_q;
  assign cand_x_o = cand_x_q;
  assign cand_y_o = cand_y_q;

endmodule

// File: rtl/pupil_marker_ctrl.sv
// Frame-level pupil marker controller: finds the darkest ROI pixel per frame and
// commits a clamped marker box at each wrap. Optional macro: PUPIL_SMOOTH_EN.
module pupil_marker_ctrl
  import pupil_pkg::*;
#(
  parameter coord_t      ROI_X0      = 13'd256,
  parameter coord_t      ROI_X1      = 13'd640,
  parameter coord_t      ROI_Y0      = 13'd8,
  parameter coord_t      ROI_Y1      = 13'd472,
  parameter coord_t      BOX_HALF    = 13'd20,
  parameter pix_t        DARK_THRESH = 10'd100,
  parameter int unsigned MISS_LIMIT  = 4,
  parameter coord_t      DEF_X       = DEF_CENTRE_X,
  parameter coord_t      DEF_Y       = DEF_CENTRE_Y
) (
  input logic iCLK,
  input logic iRST,
  pupil_marker_ctrl_if.slave bus
);

  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MISS_LIMIT);
  localparam coord_t CX_LO = ROI_X0 + BOX_HALF;
  localparam coord_t CX_HI = ROI_X1 - 13'd1 - BOX_HALF;
  localparam coord_t CY_LO = ROI_Y0 + BOX_HALF;
  localparam coord_t CY_HI = ROI_Y1 - 13'd1 - BOX_HALF;

  state_e            state_q, state_d;
  coord_t            prev_v_q;
  coord_t            cx_q, cx_d;
  coord_t            cy_q, cy_d;
  logic              valid_q, valid_d;
  pix_t              min_val_q, min_val_d;
  logic [MISS_W-1:0] miss_q, miss_d, miss_next;

  logic   wrap, commit, trk_init, trk_en, hit;
  pix_t   trk_min;
  coord_t trk_cx, trk_cy, cand_cx, cand_cy;
`ifdef PUPIL_SMOOTH_EN
  logic [COORD_W:0] sum_x, sum_y;
`endif

  // The wrap pixel only opens a frame; it is never scored.
  assign wrap   = bus.iDVAL && (bus.iV_Cont < prev_v_q);
  assign trk_en = (state_q == ST_SCAN) && bus.iEN && !wrap;

  pupil_min_tracker #(
    .ROI_X0(ROI_X0), .ROI_X1(ROI_X1), .ROI_Y0(ROI_Y0), .ROI_Y1(ROI_Y1)
  ) u_min_tracker (
    .clk_i   (iCLK),
    .rst_i   (iRST),
    .init_i  (trk_init),
    .en_i    (trk_en),
    .dval_i  (bus.iDVAL),
    .h_i     (bus.iH_Cont),
    .v_i     (bus.iV_Cont),
    .gray_i  (bus.iGRAY),
    .min_o   (trk_min),
    .cand_x_o(trk_cx),
    .cand_y_o(trk_cy)
  );

  always_comb begin
    state_d  = state_q;
    commit   = 1'b0;
    trk_init = 1'b0;
    if (!bus.iEN) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:     state_d = ST_WAIT_SOF;
        ST_WAIT_SOF: if (wrap) begin
          state_d  = ST_SCAN;
          trk_init = 1'b1;
        end
        ST_SCAN:     if (wrap) begin
          commit   = 1'b1;
          trk_init = 1'b1;
        end
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cx_d      = cx_q;
    cy_d      = cy_q;
    valid_d   = valid_q;
    min_val_d = min_val_q;
    miss_d    = miss_q;
    hit       = (trk_min <= DARK_THRESH);
    cand_cx   = clamp_coord(trk_cx, CX_LO, CX_HI);
    cand_cy   = clamp_coord(trk_cy, CY_LO, CY_HI);
    miss_next = (miss_q == MISS_MAX) ? MISS_MAX : miss_q + 1'b1;
`ifdef PUPIL_SMOOTH_EN
    sum_x     = {1'b0, cx_q} + {1'b0, cand_cx};
    sum_y     = {1'b0, cy_q} + {1'b0, cand_cy};
`endif
    if (commit) begin
      min_val_d = trk_min;
      if (hit) begin
`ifdef PUPIL_SMOOTH_EN
        cx_d = sum_x[COORD_W:1];
        cy_d = sum_y[COORD_W:1];
`else
        cx_d = cand_cx;
        cy_d = cand_cy;
`endif
        miss_d  = '0;
        valid_d = 1'b1;
      end else begin
        miss_d = miss_next;
        // Box holds through short dropouts and snaps home once the run saturates.
        if (miss_next == MISS_MAX) begin
          cx_d    = DEF_X;
          cy_d    = DEF_Y;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= ST_WAIT_SOF;
      prev_v_q  <= '0;
      cx_q      <= DEF_X;
      cy_q      <= DEF_Y;
      valid_q   <= 1'b0;
      min_val_q <= PIX_MAX;
      miss_q    <= '0;
    end else begin
      state_q   <= state_d;
      if (bus.iDVAL) prev_v_q <= bus.iV_Cont;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      valid_q   <= valid_d;
      min_val_q <= min_val_d;
      miss_q    <= miss_d;
    end
  end

  assign bus.oBOX_X0    = cx_q - BOX_HALF;
  assign bus.oBOX_X1    = cx_q + BOX_HALF;
  assign bus.oBOX_Y0    = cy_q - BOX_HALF;
  assign bus.oBOX_Y1    = cy_q + BOX_HALF;
  assign bus.oBOX_VALID = valid_q;
  assign bus.oMIN_VAL   = min_val_q;
  assign bus.oBUSY      = (state_q == ST_SCAN);

endmodule

// File: tb/tb_pupil_marker_ctrl.sv
// Self-checking bench for pupil_marker_ctrl: directed scenarios plus randomized
// frames, compared against a frame-level reference model.
module tb_pupil_marker_ctrl;
  import pupil_pkg::*;

  localparam int X0 = 256, X1 = 640, Y0 = 8, Y1 = 472;
  localparam int HALF = 20, THRESH = 100, MISS_LIM = 4, DEFX = 520, DEFY = 420;

  typedef struct packed {
    coord_t x0;
    coord_t x1;
    coord_t y0;
    coord_t y1;
    logic   valid;
    pix_t   mn;
    logic   busy;
  } outs_t;

  typedef struct {
    int h;
    int v;
    int g;
  } pix_s;

  typedef enum {M_IDLE, M_WAIT, M_SCAN} mstate_e;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pupil_marker_ctrl_if bus();

  pupil_marker_ctrl dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state, at the level of frames and pixel lists.
  mstate_e m_state;
  int      m_prev_v, m_cx, m_cy, m_miss, m_min;
  bit      m_valid;
  pix_s    m_frame[$];

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic void model_reset();
    m_state  = M_WAIT;
    m_prev_v = 0;
    m_cx     = DEFX;
    m_cy     = DEFY;
    m_miss   = 0;
    m_min    = 1023;
    m_valid  = 1'b0;
    m_frame.delete();
  endfunction

  function automatic void model_commit();
    int best = 1023, bx = 0, by = 0, nx, ny;
    foreach (m_frame[i]) begin
      if (m_frame[i].h >= X0 && m_frame[i].h < X1 && m_frame[i].v >= Y0 &&
          m_frame[i].v < Y1 && m_frame[i].g < best) begin
        best = m_frame[i].g;
        bx   = m_frame[i].h;
        by   = m_frame[i].v;
      end
    end
    m_min = best;
    if (best <= THRESH) begin
      nx = clampi(bx, X0 + HALF, X1 - 1 - HALF);
      ny = clampi(by, Y0 + HALF, Y1 - 1 - HALF);
`ifdef PUPIL_SMOOTH_EN
      m_cx = (m_cx + nx) / 2;
      m_cy = (m_cy + ny) / 2;
`else
      m_cx = nx;
      m_cy = ny;
`endif
      m_miss  = 0;
      m_valid = 1'b1;
    end else begin
      if (m_miss < MISS_LIM) m_miss++;
      if (m_miss == MISS_LIM) begin
        m_cx    = DEFX;
        m_cy    = DEFY;
        m_valid = 1'b0;
      end
    end
  endfunction

  function automatic void model_clock(input bit en, input bit dval, input int h, input int v,
                                      input int g);
    bit wrap = dval && (v < m_prev_v);
    if (dval) m_prev_v = v;
    if (!en) begin
      m_state = M_IDLE;
      m_frame.delete();
    end else begin
      case (m_state)
        M_IDLE: m_state = M_WAIT;
        M_WAIT: if (wrap) begin
          m_state = M_SCAN;
          m_frame.delete();
        end
        M_SCAN: begin
          if (wrap) begin
            model_commit();
            m_frame.delete();
          end else if (dval) begin
            m_frame.push_back('{h, v, g});
          end
        end
        default: m_state = M_IDLE;
      endcase
    end
  endfunction

  function automatic outs_t get_obs();
    return {bus.oBOX_X0, bus.oBOX_X1, bus.oBOX_Y0, bus.oBOX_Y1, bus.oBOX_VALID, bus.oMIN_VAL,
            bus.oBUSY};
  endfunction

  function automatic outs_t get_exp();
    outs_t e;
    e.x0    = coord_t'(m_cx - HALF);
    e.x1    = coord_t'(m_cx + HALF);
    e.y0    = coord_t'(m_cy - HALF);
    e.y1    = coord_t'(m_cy + HALF);
    e.valid = m_valid;
    e.mn    = pix_t'(m_min);
    e.busy  = (m_state == M_SCAN);
    return e;
  endfunction

  function automatic string fmt(input outs_t o);
    return $sformatf("box=%0d/%0d/%0d/%0d valid=%0b min=%0h busy=%0b", o.x0, o.x1, o.y0, o.y1,
                     o.valid, o.mn, o.busy);
  endfunction

  // One clock of stimulus; returns 1 time unit after the edge so outputs are settled.
  task automatic drive(input bit en, input bit dval, input int h, input int v, input int g);
    @(negedge clk);
    rst          = 1'b0;
    bus.iEN      = en;
    bus.iDVAL    = dval;
    bus.iH_Cont  = coord_t'(h);
    bus.iV_Cont  = coord_t'(v);
    bus.iGRAY    = pix_t'(g);
    @(posedge clk);
    model_clock(en, dval, h, v, g);
    #1;
  endtask

  task automatic send_frame(input pix_s q[$]);
    foreach (q[i]) begin
      drive(1'b1, 1'b1, q[i].h, q[i].v, q[i].g);
      if (i % 2 == 1) drive(1'b1, 1'b0, 0, 0, 0);
    end
    drive(1'b1, 1'b1, 0, 0, 512);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    bus.iEN   = 1'b1;
    bus.iDVAL = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic sync_to_scan();
    pix_s q[$];
    q.push_back('{0, 5, 512});
    send_frame(q);
  endtask

  task automatic test_reset();
    outs_t obs, exp_o, lit;
    do_reset();
    lit = {13'd500, 13'd540, 13'd400, 13'd440, 1'b0, 10'h3FF, 1'b0};
    obs = get_obs();
    exp_o = get_exp();
    checks++;
    if (obs !== lit) begin
      errors++;
      $display("FAIL reset_values: got %s want %s", fmt(obs), fmt(lit));
    end
    checks++;
    if (obs !== exp_o) begin
      errors++;
      $display("FAIL reset_model: got %s want %s", fmt(obs), fmt(exp_o));
    end
    sync_to_scan();
    obs = get_obs();
    exp_o = get_exp();
    checks++;
    if (obs !== exp_o) begin
      errors++;
      $display("FAIL first_wrap_busy: got %s want %s", fmt(obs), fmt(exp_o));
    end
  endtask

  task automatic test_single_dark();
    pix_s q[$];
    outs_t obs, exp_o;
    q = '{'{300, 7, 0}, '{260, 10, 512}, '{255, 100, 0}, '{300, 200, 40}, '{640, 300, 0},
          '{500, 300, 512}, '{639, 471, 512}, '{300, 472, 0}};
    send_frame(q);
    obs = get_obs();
    exp_o = get_exp();
    checks++;
    if (obs !== exp_o) begin
      errors++;
      $display("FAIL single_dark: got %s want %s", fmt(obs), fmt(exp_o));
    end
  endtask

  task automatic test_clamp_tie();
    pix_s q[$];
    outs_t obs, exp_o;
    q = '{'{260, 10, 10}, '{400, 300, 10}, '{639, 471, 11}};
    send_frame(q);
    obs = get_obs();
    exp_o = get_exp();
    checks++;
    if (obs !== exp_o) begin
      errors++;
      $display("FAIL clamp_tie: got %s want %s", fmt(obs), fmt(exp_o));
    end
  endtask

  task automatic test_miss();
    pix_s q[$];
    outs_t obs, exp_o;
    q = '{'{300, 200, 50}};
    send_frame(q);
    obs = get_obs();
    exp_o = get_exp();
    checks++;
    if (obs !== exp_o) begin
      errors++;
      $display("FAIL miss_prehit: got %s want %s", fmt(obs), fmt(exp_o));
    end
    q = '{'{300, 100, 150}, '{400, 200, 200}};
    for (int f = 1; f <= 5; f++) begin
      send_frame(q);
      obs = get_obs();
      exp_o = get_exp();
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL miss_frame%0d: got %s want %s", f, fmt(obs), fmt(exp_o));
      end
    end
    // Frame with no ROI pixel at all.
    q = '{'{100, 100, 0}, '{700, 300, 0}};
    send_frame(q);
    obs = get_obs();
    exp_o = get_exp();
    checks++;
    if (obs !== exp_o) begin
      errors++;
      $display("FAIL empty_frame: got %s want %s", fmt(obs), fmt(exp_o));
    end
  endtask

  task automatic test_enable();
    pix_s q[$];
    outs_t obs, exp_o;
    q = '{'{300, 200, 60}};
    send_frame(q);
    drive(1'b1, 1'b1, 300, 100, 512);
    drive(1'b1, 1'b1, 320, 150, 5);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 0, 0, 0);
      obs = get_obs();
      exp_o = get_exp();
      checks++;
      if (obs !== exp_o) begin
        errors++;
        $display("FAIL enable_off%0d: got %s want %s", i, fmt(obs), fmt(exp_o));
      end
    end
    drive(1'b1, 1'b0, 0, 0, 0);
    q = '{'{300, 300, 1}, '{300, 400, 512}};
    send_frame(q);
    obs = get_obs();
    exp_o = get_exp();
    checks++;
    if (obs !== exp_o) begin
      errors++;
      $display("FAIL enable_partial: got %s want %s", fmt(obs), fmt(exp_o));
    end
    q = '{'{350, 250, 30}};
    send_frame(q);
    obs = get_obs();
    exp_o = get_exp();
    checks++;
    if (obs !== exp_o) begin
      errors++;
      $display("FAIL enable_full: got %s want %s", fmt(obs), fmt(exp_o));
    end
  endtask

  task automatic test_reset_midframe();
    outs_t obs, exp_o;
    drive(1'b1, 1'b1, 300, 100, 3);
    do_reset();
    obs = get_obs();
    exp_o = get_exp();
    checks++;
    if (obs !== exp_o) begin
      errors++;
      $display("FAIL reset_midframe: got %s want %s", fmt(obs), fmt(exp_o));
    end
    sync_to_scan();
  endtask

  task automatic test_random();
    outs_t obs, exp_o;
    int v, n;
    bit en;
    for (int f = 0; f < 60; f++) begin
      n = $urandom_range(0, 12);
      v = 1;
      for (int i = 0; i <= n; i++) begin
        en = ($urandom_range(0, 99) >= 3);
        if (i == n) begin
          drive(en, 1'b1, 0, 0, $urandom_range(0, 1023));
        end else begin
          v = v + $urandom_range(0, 60);
          drive(en, $urandom_range(0, 3) != 0, $urandom_range(200, 700), v,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 120) : $urandom_range(101, 1023));
        end
        obs = get_obs();
        exp_o = get_exp();
        checks++;
        if (obs !== exp_o) begin
          errors++;
          $display("FAIL random f%0d c%0d: got %s want %s", f, i, fmt(obs), fmt(exp_o));
        end
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.iEN     = 1'b0;
    bus.iDVAL   = 1'b0;
    bus.iH_Cont = '0;
    bus.iV_Cont = '0;
    bus.iGRAY   = '0;
    test_reset();
    test_single_dark();
    test_clamp_tie();
    test_miss();
    test_enable();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
